// File: rtl/serial_tx_uart.sv
// Buffered UART transmitter: byte FIFO in front of an 8N1 serializer (8E1 when
// SERIAL_TX_UART_PARITY_EN is defined). Ports are identical in both builds.
module serial_tx_uart #(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    serial_data_in,
  input  logic                          serial_wren_in,
  output logic                          serial_ready_out,
  output logic                          tx_out,
  output logic                          busy_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      BAUD_LAST = 16'(BAUD_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Handshake: a byte is taken on any edge where serial_wren_in and
  // serial_ready_out are both high; ready depends only on count and reset.
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  state_t           state, state_d;
  logic [15:0]      baud_cnt, baud_d;
  logic [2:0]       bit_idx, bit_d;
  logic [7:0]       shift_reg, shift_d;
  logic             tx_q, tx_d;
  logic             push, pop;

  assign serial_ready_out = reset && (count != FULL_CNT);
  assign push             = serial_wren_in && serial_ready_out;
  assign pop              = (state == IDLE) && (count != '0);
  assign busy_out         = (state != IDLE) || (count != '0);
  assign fifo_count_out   = count;
  assign tx_out           = tx_q;

  always_comb begin
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_idx;
    shift_d = shift_reg;
    if (state == IDLE) begin
      if (pop) begin
        state_d = START;
        baud_d  = '0;
        shift_d = mem[rd_ptr];
      end
    end else if (baud_cnt == BAUD_LAST) begin
      baud_d = '0;
      case (state)
        START: begin
          state_d = DATA;
          bit_d   = '0;
        end
        DATA: begin
          if (bit_idx == 3'd7) begin
`ifdef SERIAL_TX_UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_idx + 3'd1;
          end
        end
        PARITY:  state_d = STOP;
        default: state_d = IDLE;
      endcase
    end else begin
      baud_d = baud_cnt + 16'd1;
    end

    // Line level is decided from the next state so tx_out comes straight from a flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_d];
      PARITY:  tx_d = ^shift_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_q      <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_d;
      baud_cnt  <= baud_d;
      bit_idx   <= bit_d;
      shift_reg <= shift_d;
      tx_q      <= tx_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= serial_data_in;
  end

endmodule

// File: tb/tb_serial_tx_uart.sv
// Bench for serial_tx_uart (BAUD_DIV=4, FIFO_DEPTH=4): frame-timing reference
// model, line receiver with expected-byte queue, directed vectors and sequences.
module tb_serial_tx_uart;

  localparam int B = 4;
  localparam int D = 4;
`ifdef SERIAL_TX_UART_PARITY_EN
  localparam int FB  = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int FB  = 10;
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = FB * B;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] serial_data_in = 8'h00;
  logic       serial_wren_in = 1'b0;
  logic       serial_ready_out, tx_out, busy_out;
  logic [2:0] fifo_count_out;

  serial_tx_uart #(.BAUD_DIV(B), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .serial_data_in(serial_data_in),
    .serial_wren_in(serial_wren_in), .serial_ready_out(serial_ready_out),
    .tx_out(tx_out), .busy_out(busy_out), .fifo_count_out(fifo_count_out)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: queue of waiting bytes plus the pop edge of the current frame
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] cur_byte;
  int         edge_n = 0;
  int         pop_edge = 0;
  bit         has_frame = 1'b0;
  bit         m_idle, m_push, m_pop, m_active;
  logic       m_tx;
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  int         rx_slot;
  logic [7:0] rx_byte;
  int         rx_bytes = 0;

  function automatic logic line_level(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (PAR && slot == 9) return ^b;
    return 1'b1;
  endfunction

  always @(posedge clock) begin
    edge_n++;
    if (!reset) begin
      m_q.delete();
      exp_q.delete();
      has_frame = 1'b0;
    end else begin
      m_idle = !has_frame || (edge_n - 1 - pop_edge >= FRAME);
      m_push = serial_wren_in && (m_q.size() < D);
      m_pop  = m_idle && (m_q.size() > 0);
      if (m_pop) begin
        cur_byte  = m_q.pop_front();
        pop_edge  = edge_n;
        has_frame = 1'b1;
      end
      if (m_push) begin
        m_q.push_back(serial_data_in);
        exp_q.push_back(serial_data_in);
      end
    end
    #1;
    m_active = has_frame && (edge_n - pop_edge < FRAME);
    m_tx = m_active ? line_level(cur_byte, (edge_n - pop_edge) / B) : 1'b1;
    chk("model_tx", tx_out, m_tx);
    chk("model_busy", busy_out, m_active || (m_q.size() > 0));
    chk("model_ready", serial_ready_out, reset && (m_q.size() < D));
    chk("model_count", fifo_count_out, m_q.size());

    // line receiver sampling mid-bit
    if (!reset) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (tx_out === 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % B == B / 2) begin
        rx_slot = rx_cnt / B;
        if (rx_slot >= 1 && rx_slot <= 8) rx_byte[rx_slot-1] = tx_out;
        if (PAR && rx_slot == 9) chk("rx_parity", tx_out, ^rx_byte);
        if (rx_slot == FB - 1) begin
          chk("rx_stop", tx_out, 1'b1);
          chk("rx_q_nonempty", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) chk("rx_byte", rx_byte, exp_q.pop_front());
          rx_bytes++;
          rx_act = 1'b0;
        end
      end
    end
  end

  // driver tasks
  task automatic write_byte(input logic [7:0] d);
    @(negedge clock);
    serial_wren_in = 1'b1;
    serial_data_in = d;
    @(negedge clock);
    serial_wren_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_out !== 1'b0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk("idle_wait", busy_out, 1'b0);
  endtask

  task automatic wait_tx(input logic v, output int n);
    n = 0;
    while (tx_out !== v && n < 500) begin
      @(negedge clock);
      n++;
    end
    chk("tx_wait", tx_out, v);
  endtask

  typedef struct {
    logic [7:0]    data;
    logic [FB-1:0] line;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int k, n, gap, total, lows, base;
    logic [FB-1:0] got;

`ifdef SERIAL_TX_UART_PARITY_EN
    vecs[0] = '{8'hA5, 11'b10101001010};
    vecs[1] = '{8'h00, 11'b10000000000};
    vecs[2] = '{8'hFF, 11'b10111111110};
    vecs[3] = '{8'h07, 11'b11000001110};
    vecs[4] = '{8'h03, 11'b10000000110};
    vecs[5] = '{8'h3C, 11'b10001111000};
`else
    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h07, 10'b1000001110};
    vecs[4] = '{8'h03, 10'b1000000110};
    vecs[5] = '{8'h3C, 10'b1001111000};
`endif

    // reset held 3 cycles with a write strobe asserted
    serial_wren_in = 1'b1;
    serial_data_in = 8'h55;
    repeat (3) begin
      @(negedge clock);
      chk("rst_tx", tx_out, 1'b1);
      chk("rst_ready", serial_ready_out, 1'b0);
      chk("rst_count", fifo_count_out, 3'd0);
    end
    serial_wren_in = 1'b0;
    reset = 1'b1;
    repeat (20) @(negedge clock);
    chk("post_rst_busy", busy_out, 1'b0);
    chk("post_rst_tx", tx_out, 1'b1);

    // single-frame vectors: 2-cycle latency then mid-bit line samples
    for (int v = 0; v < 6; v++) begin
      wait_idle();
      @(negedge clock);
      serial_wren_in = 1'b1;
      serial_data_in = vecs[v].data;
      @(negedge clock);
      serial_wren_in = 1'b0;
      chk("lat_high", tx_out, 1'b1);
      @(negedge clock);
      k = 1;
      chk("lat_fall", tx_out, 1'b0);
      for (int s = 0; s < FB; s++) begin
        while (k < 2 + s * B) begin
          @(negedge clock);
          k++;
        end
        got[s] = tx_out;
      end
      chk("frame_line", got, vecs[v].line);
    end

    // overflow: six back-to-back writes into a depth-4 FIFO
    wait_idle();
    base = rx_bytes;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      if (i == 6) begin
        chk("ovf_ready", serial_ready_out, 1'b0);
        chk("ovf_count", fifo_count_out, 3'd4);
      end
      serial_wren_in = 1'b1;
      serial_data_in = 8'(i);
    end
    @(negedge clock);
    serial_wren_in = 1'b0;
    wait_idle();
    chk("ovf_frames", rx_bytes - base, 5);

    // back-to-back 0x00, 0xFF: inter-frame high gap and total activity
    wait_idle();
    @(negedge clock);
    serial_wren_in = 1'b1;
    serial_data_in = 8'h00;
    @(negedge clock);
    serial_data_in = 8'hFF;
    @(negedge clock);
    serial_wren_in = 1'b0;
    wait_tx(1'b0, n);
    total = n;
    wait_tx(1'b1, n);
    total += n;
    wait_tx(1'b0, gap);
    total += gap;
    chk("b2b_gap", gap, B + 1);
    n = 0;
    while (busy_out !== 1'b0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    total += n;
    chk("b2b_total", total, 2 * FRAME + 1);

    // reset during data bit 3 of 0x3C
    wait_idle();
    write_byte(8'h3C);
    repeat (1 + 4 * B) @(negedge clock);
    chk("mid_bit3", tx_out, 1'b1);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_tx", tx_out, 1'b1);
    chk("mid_rst_count", fifo_count_out, 3'd0);
    chk("mid_rst_busy", busy_out, 1'b0);
    reset = 1'b1;
    lows = 0;
    repeat (3 * FRAME) begin
      @(negedge clock);
      if (tx_out !== 1'b1) lows++;
    end
    chk("mid_rst_silent", lows, 0);

    // randomized writes against the model
    repeat (600) begin
      @(negedge clock);
      serial_wren_in = ($urandom_range(0, 3) == 0);
      serial_data_in = 8'($urandom);
    end
    @(negedge clock);
    serial_wren_in = 1'b0;
    wait_idle();
    repeat (4) @(negedge clock);
    chk("drain_exp_q", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_tx_uart.md
# serial_tx_uart

Buffered UART transmitter that sits directly downstream of the processor's serial output port. It accepts bytes presented on the data memory's `serial_out`/`serial_wren_out` pair and queues them in a small FIFO. It returns backpressure on the processor's `serial_ready_in`. Queued bytes are shifted out LSB-first as asynchronous 8N1 frames on a single line at a fixed baud divisor.

## Interface
- `BAUD_DIV`, 434: clock cycles per serial bit; legal range 2..65535.
- `FIFO_DEPTH`, 16: byte entries; power of two, 2..256.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low; state clears on a rising edge while `reset`=0.
- `serial_data_in`  in  8  byte from processor `serial_out`.
- `serial_wren_in`  in  1  write strobe from processor `serial_wren_out`.
- `serial_ready_out`  out  1  to processor `serial_ready_in`; high = a write this cycle will be accepted.
- `tx_out`  out  1  UART line; idle high.
- `busy_out`  out  1  high while a frame is on the line or FIFO non-empty.
- `fifo_count_out`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Reset values:**
  - `tx_out`=1, `busy_out`=0, `fifo_count_out`=0.
  - `serial_ready_out`=0 during any cycle with `reset`=0, otherwise `!full`.
  - FSM=IDLE, baud counter=0, FIFO pointers=0.
- **Push:** on an edge where `serial_wren_in`=1 and `serial_ready_out`=1, `serial_data_in` is written at the write pointer, and the pointer and count increment.
  - Writes while full are dropped silently; no state change.
- **Pop:** occurs only in IDLE with count>0. The head byte is loaded into the shift register, the read pointer advances, and the count decrements. Next state is START.
- **Pointers** wrap modulo `FIFO_DEPTH`. Count is a separate register (0..FIFO_DEPTH) and never wraps.
- **Simultaneous push and pop:** the count is unchanged and both pointers advance.
  - Push when empty plus IDLE in the same cycle: the pop sees empty, so the byte is popped on the next cycle.
  - Push when full is refused even if a pop occurs in the same cycle, because `serial_ready_out` is computed from the pre-edge count.
- **FSM states and transitions:**
  - IDLE: `tx_out`=1.
  - START: `tx_out`=0, lasts BAUD_DIV cycles.
  - DATA: 8 bits, bit 0 first, each BAUD_DIV cycles; 3-bit bit index.
  - PARITY: present only with the macro.
  - STOP: `tx_out`=1, BAUD_DIV cycles, then returns to IDLE.
- **Baud counter** runs 0..BAUD_DIV-1 and reloads to 0 at each bit boundary. Its width is 16 bits.
- **`tx_out`** is driven from a register; no combinational path from inputs to `tx_out`.
- **`busy_out`** = (state≠IDLE) || (count≠0).

## Timing
- **Accept to line:** a byte accepted at edge N into an empty FIFO while IDLE is popped at edge N+1, and `tx_out` falls after edge N+1. Start-of-frame latency is 2 cycles.
- **Frame length:** 10·BAUD_DIV cycles (11·BAUD_DIV with parity).
- **Back-to-back frames:** the line stays high for BAUD_DIV+1 cycles between frames (STOP plus one IDLE pop cycle).
- **`serial_ready_out`** is combinational from the count register and reset only; there is no input-to-output path.
- **Reset mid-frame:** the FSM returns to IDLE, `tx_out` goes to 1 after that edge, the FIFO is flushed, and the partial frame is abandoned.

## Configuration
- `SERIAL_TX_UART_PARITY_EN` defined: a PARITY state of BAUD_DIV cycles is inserted between DATA and STOP. It carries even parity (XOR of the 8 data bits), giving 8E1 frames of 11 bits.
- Undefined: no PARITY state; 8N1 frames of 10 bits. Ports are identical in both builds.

## Test plan
All scenarios use BAUD_DIV=4 and FIFO_DEPTH=4.
- **Reset:** hold `reset`=0 for 3 cycles with `serial_wren_in`=1 → `tx_out`=1, `serial_ready_out`=0, count=0; nothing transmitted after release.
- **Single byte 0xA5:** single write → `tx_out` falls 2 cycles later. Line sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. `busy_out` drops after the STOP bit plus 1 cycle.
- **Overflow:** 6 consecutive writes 0x01..0x06 starting while idle → bytes 0x01..0x05 accepted (one popped early), `serial_ready_out` low once count=4, 0x06 dropped. Frames out: 0x01,0x02,0x03,0x04,0x05.
- **Back-to-back 0x00, 0xFF:** 5 idle-high cycles between the two stop/start boundaries; total 2×40+1 cycles of activity.
- **Mid-frame reset:** `reset`=0 during DATA bit 3 of 0x3C → `tx_out`=1 next cycle, count=0, no further frames.
- **Parity build:** 0x07 → parity bit 1, frame 11 bits (44 cycles). 0x03 → parity bit 0.
